rf_wb_queue: RTL and testbench

- In-order writeback queue that sits between the execute/memory result producers and the 2-write-port register file.
- Accepts up to two results per cycle from two producer channels over valid/ready.
- Buffers results in a small circular FIFO and drives the register-file write ports (W1E/WAddr1/WData1, W2E/WAddr2/WData2) from registers.
- Preserves program order and guarantees no two same-cycle writes target one register.

---
 rtl/rf_wb_queue.sv | 196 +++++++++++++++++++
 tb/tb_rf_wb_queue.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_queue
// Function : In-order writeback queue feeding a 2-write-port register file.
//            Optional hazard lookup ports are enabled by RF_WB_PENDING_EN.
// Revision : 1.0
// ============================================================================
module rf_wb_queue #(
  parameter int ADDR_SIZE  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    P0Valid,
  input  logic [ADDR_SIZE-1:0]    P0Addr,
  input  logic [DATA_WIDTH-1:0]   P0Data,
  output logic                    P0Ready,
  input  logic                    P1Valid,
  input  logic [ADDR_SIZE-1:0]    P1Addr,
  input  logic [DATA_WIDTH-1:0]   P1Data,
  output logic                    P1Ready,
  output logic                    W1E,
  output logic [ADDR_SIZE-1:0]    WAddr1,
  output logic [DATA_WIDTH-1:0]   WData1,
  output logic                    W2E,
  output logic [ADDR_SIZE-1:0]    WAddr2,
  output logic [DATA_WIDTH-1:0]   WData2,
  output logic                    Empty,
  output logic                    Full,
  output logic [$clog2(DEPTH):0]  Count
`ifdef RF_WB_PENDING_EN
  ,
  input  logic [ADDR_SIZE-1:0]    QAddr1,
  input  logic [ADDR_SIZE-1:0]    QAddr2,
  input  logic [ADDR_SIZE-1:0]    QAddr3,
  input  logic [ADDR_SIZE-1:0]    QAddr4,
  output logic                    Pend1,
  output logic                    Pend2,
  output logic                    Pend3,
  output logic                    Pend4
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);

  logic [ADDR_SIZE-1:0]  addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [PW-1:0]         head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
  logic [CW-1:0]         count_q, count_d, avail;
  logic                  empty_q, full_q;
  logic                  w1e_q, w1e_d, w2e_q, w2e_d;
  logic [ADDR_SIZE-1:0]  waddr1_q, waddr1_d, waddr2_q, waddr2_d;
  logic [DATA_WIDTH-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;

  logic                  acc0, acc1, st0, st1;
  logic [1:0]            enq, deq;
  logic [ADDR_SIZE-1:0]  in0_addr, in1_addr, e0_addr, e1_addr;
  logic [DATA_WIDTH-1:0] in0_data, in1_data, e0_data, e1_data;

  assign P0Ready = (count_q < DEPTH_C);
  assign P1Ready = (count_q <= DEPTH_M2);

  assign head_p1 = head_q + PW'(1);
  assign tail_p1 = tail_q + PW'(1);

  always_comb begin
    acc0     = P0Valid && P0Ready;
    acc1     = P1Valid && P1Ready;
    st0      = acc0 && (P0Addr != '0);
    st1      = acc1 && (P1Addr != '0);
    enq      = {1'b0, st0} + {1'b0, st1};
    in0_addr = st0 ? P0Addr : P1Addr;
    in0_data = st0 ? P0Data : P1Data;
    in1_addr = P1Addr;
    in1_data = P1Data;
    avail    = count_q + CW'(enq);

    // Issue window: oldest two entries of the stored queue followed by this
    // cycle's arrivals, so an empty queue forwards a result with one cycle latency.
    if (count_q != '0) begin
      e0_addr = addr_q[head_q];
      e0_data = data_q[head_q];
    end else begin
      e0_addr = in0_addr;
      e0_data = in0_data;
    end
    if (count_q >= CW'(2)) begin
      e1_addr = addr_q[head_p1];
      e1_data = data_q[head_p1];
    end else if (count_q == CW'(1)) begin
      e1_addr = in0_addr;
      e1_data = in0_data;
    end else begin
      e1_addr = in1_addr;
      e1_data = in1_data;
    end

    deq = 2'd0;
    if (avail != '0) deq = 2'd1;
    if ((avail >= CW'(2)) && (e1_addr != e0_addr)) deq = 2'd2;

    w1e_d    = (deq != 2'd0);
    waddr1_d = w1e_d ? e0_addr : waddr1_q;
    wdata1_d = w1e_d ? e0_data : wdata1_q;
    w2e_d    = (deq == 2'd2);
    waddr2_d = w2e_d ? e1_addr : waddr2_q;
    wdata2_d = w2e_d ? e1_data : wdata2_q;

    head_d   = head_q + PW'(deq);
    tail_d   = tail_q + PW'(enq);
    count_d  = avail - CW'(deq);
  end

  // Arrivals are always written at tail; forwarded ones are simply skipped by head.
  always_ff @(posedge CLK) begin
    if (st0 || st1) begin
      addr_q[tail_q] <= in0_addr;
      data_q[tail_q] <= in0_data;
    end
    if (st0 && st1) begin
      addr_q[tail_p1] <= in1_addr;
      data_q[tail_p1] <= in1_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      w1e_q    <= 1'b0;
      waddr1_q <= '0;
      wdata1_q <= '0;
      w2e_q    <= 1'b0;
      waddr2_q <= '0;
      wdata2_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      empty_q  <= (count_d == '0);
      full_q   <= (count_d == DEPTH_C);
      w1e_q    <= w1e_d;
      waddr1_q <= waddr1_d;
      wdata1_q <= wdata1_d;
      w2e_q    <= w2e_d;
      waddr2_q <= waddr2_d;
      wdata2_q <= wdata2_d;
    end
  end

  assign W1E    = w1e_q;
  assign WAddr1 = waddr1_q;
  assign WData1 = wdata1_q;
  assign W2E    = w2e_q;
  assign WAddr2 = waddr2_q;
  assign WData2 = wdata2_q;
  assign Empty  = empty_q;
  assign Full   = full_q;
  assign Count  = count_q;

`ifdef RF_WB_PENDING_EN
  logic [DEPTH-1:0] live;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = ({1'b0, PW'(PW'(i) - head_q)} < count_q);
    end
  end

  function automatic logic pend_hit(input logic [ADDR_SIZE-1:0] qa);
    logic hit;
    hit = (w1e_q && (waddr1_q == qa)) || (w2e_q && (waddr2_q == qa));
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (addr_q[i] == qa)) hit = 1'b1;
    end
    return hit && (qa != '0);
  endfunction

  always_comb begin
    Pend1 = pend_hit(QAddr1);
    Pend2 = pend_hit(QAddr2);
    Pend3 = pend_hit(QAddr3);
    Pend4 = pend_hit(QAddr4);
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_queue
// Function : Scoreboard testbench for rf_wb_queue (RF_WB_PENDING_EN optional).
// Revision : 1.0
// ============================================================================
module tb_rf_wb_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic        CLK, RST;
  logic        P0Valid, P1Valid;
  logic [4:0]  P0Addr, P1Addr;
  logic [31:0] P0Data, P1Data;
  logic        P0Ready, P1Ready;
  logic        W1E, W2E;
  logic [4:0]  WAddr1, WAddr2;
  logic [31:0] WData1, WData2;
  logic        Empty, Full;
  logic [2:0]  Count;
`ifdef RF_WB_PENDING_EN
  logic [4:0]  QAddr1, QAddr2, QAddr3, QAddr4;
  logic        Pend1, Pend2, Pend3, Pend4;
`endif

  rf_wb_queue #(.ADDR_SIZE(5), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .P0Valid(P0Valid), .P0Addr(P0Addr), .P0Data(P0Data), .P0Ready(P0Ready),
    .P1Valid(P1Valid), .P1Addr(P1Addr), .P1Data(P1Data), .P1Ready(P1Ready),
    .W1E(W1E), .WAddr1(WAddr1), .WData1(WData1),
    .W2E(W2E), .WAddr2(WAddr2), .WData2(WData2),
    .Empty(Empty), .Full(Full), .Count(Count)
`ifdef RF_WB_PENDING_EN
    ,
    .QAddr1(QAddr1), .QAddr2(QAddr2), .QAddr3(QAddr3), .QAddr4(QAddr4),
    .Pend1(Pend1), .Pend2(Pend2), .Pend3(Pend3), .Pend4(Pend4)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t mq[$];
  ent_t sbq[$];
  logic [31:0] rf [32];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [4:0] a, input logic [31:0] d);
    ent_t e;
    if (sbq.size() == 0) begin
      check_eq({tag, "_unexpected_write"}, 64'(a), 64'd0);
    end else begin
      e = sbq.pop_front();
      check_eq({tag, "_entry"}, {27'd0, a, d}, {27'd0, e.a, e.d});
    end
  endtask

  // One clock: drive inputs, advance the reference queue, then check outputs.
  task automatic step(input bit v0, input logic [4:0] a0, input logic [31:0] d0,
                      input bit v1, input logic [4:0] a1, input logic [31:0] d1);
    bit r0, r1;
    int n, dq;
    r0 = (mq.size() < DEPTH);
    r1 = (mq.size() <= DEPTH - 2);
    check_eq("p0ready", 64'(P0Ready), 64'(r0));
    check_eq("p1ready", 64'(P1Ready), 64'(r1));
    P0Valid = v0; P0Addr = a0; P0Data = d0;
    P1Valid = v1; P1Addr = a1; P1Data = d1;
    if (v0 && r0 && a0 != 5'd0) begin mq.push_back('{a0, d0}); sbq.push_back('{a0, d0}); end
    if (v1 && r1 && a1 != 5'd0) begin mq.push_back('{a1, d1}); sbq.push_back('{a1, d1}); end
    n  = mq.size();
    dq = 0;
    if (n >= 1) dq = 1;
    if (n >= 2 && mq[1].a != mq[0].a) dq = 2;
    repeat (dq) void'(mq.pop_front());
    @(posedge CLK); #1;
    P0Valid = 1'b0; P1Valid = 1'b0;
    check_eq("w1e", 64'(W1E), 64'(dq >= 1));
    check_eq("w2e", 64'(W2E), 64'(dq == 2));
    check_eq("count", 64'(Count), 64'(mq.size()));
    check_eq("empty", 64'(Empty), 64'(mq.size() == 0));
    check_eq("full", 64'(Full), 64'(mq.size() == DEPTH));
    if (W1E) begin
      sb_pop("port1", WAddr1, WData1);
      rf[WAddr1] = WData1;
    end
    if (W2E) begin
      sb_pop("port2", WAddr2, WData2);
      check_eq("port2_addr_differs", 64'(WAddr2 != WAddr1), 64'd1);
      rf[WAddr2] = WData2;
    end
  endtask

  task automatic idle();
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    P0Valid = 0; P0Addr = 0; P0Data = 0;
    P1Valid = 0; P1Addr = 0; P1Data = 0;
`ifdef RF_WB_PENDING_EN
    QAddr1 = 0; QAddr2 = 0; QAddr3 = 0; QAddr4 = 0;
`endif
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_w1e", 64'(W1E), 64'd0);
    check_eq("rst_w2e", 64'(W2E), 64'd0);
    check_eq("rst_waddr1", 64'(WAddr1), 64'd0);
    check_eq("rst_wdata2", 64'(WData2), 64'd0);
    check_eq("rst_empty", 64'(Empty), 64'd1);
    check_eq("rst_full", 64'(Full), 64'd0);
    check_eq("rst_count", 64'(Count), 64'd0);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;

    // Single result, one-cycle latency from an empty queue
    step(1, 5'd5, 32'h1234, 0, 5'd0, 32'd0);
    check_eq("single_waddr1", 64'(WAddr1), 64'd5);
    check_eq("single_wdata1", 64'(WData1), 64'h1234);
    idle();
    check_eq("hold_waddr1", 64'(WAddr1), 64'd5);

    // Dual issue
    step(1, 5'd3, 32'hA, 1, 5'd4, 32'hB);
    check_eq("dual_port1", {27'd0, WAddr1, WData1}, {27'd0, 5'd3, 32'hA});
    check_eq("dual_port2", {27'd0, WAddr2, WData2}, {27'd0, 5'd4, 32'hB});

    // Same-address serialisation: youngest value lands last
    step(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
    check_eq("same_n1_port1", {27'd0, WAddr1, WData1}, {27'd0, 5'd7, 32'h1});
    idle();
    check_eq("same_n2_port1", {27'd0, WAddr1, WData1}, {27'd0, 5'd7, 32'h2});
    check_eq("same_final_r7", 64'(rf[7]), 64'h2);

    // Fill to three entries with a same-address stream, then back-pressure and r0
    step(1, 5'd10, 32'h100, 1, 5'd10, 32'h101);
    step(1, 5'd10, 32'h102, 1, 5'd10, 32'h103);
    step(1, 5'd10, 32'h104, 1, 5'd10, 32'h105);
    check_eq("bp_count3", 64'(Count), 64'd3);
    check_eq("bp_p0ready", 64'(P0Ready), 64'd1);
    check_eq("bp_p1ready", 64'(P1Ready), 64'd0);
    step(1, 5'd0, 32'hFF, 1, 5'd11, 32'h77);
    check_eq("r0_count", 64'(Count), 64'd2);
    step(1, 5'd10, 32'h106, 1, 5'd10, 32'h107);
    check_eq("pre_rst_count", 64'(Count), 64'd3);

    // Asynchronous reset mid-cycle drops everything
    #3 RST = 1'b1;
    #1;
    check_eq("midrst_w1e", 64'(W1E), 64'd0);
    check_eq("midrst_w2e", 64'(W2E), 64'd0);
    check_eq("midrst_count", 64'(Count), 64'd0);
    check_eq("midrst_empty", 64'(Empty), 64'd1);
    mq.delete();
    sbq.delete();
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    repeat (3) idle();

`ifdef RF_WB_PENDING_EN
    QAddr1 = 5'd9; QAddr2 = 5'd0;
    step(1, 5'd9, 32'h99, 0, 5'd0, 32'd0);
    check_eq("pend1_issue", 64'(Pend1), 64'd1);
    check_eq("pend2_zero", 64'(Pend2), 64'd0);
    idle();
    check_eq("pend1_after", 64'(Pend1), 64'd0);
    step(1, 5'd9, 32'h1, 1, 5'd9, 32'h2);
    check_eq("pend1_queued", 64'(Pend1), 64'd1);
    idle();
    check_eq("pend1_issue2", 64'(Pend1), 64'd1);
    idle();
    check_eq("pend1_drop2", 64'(Pend1), 64'd0);
    QAddr1 = 5'd0;
`endif

    // Random traffic over a small address range to provoke collisions
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)), $urandom);
    end
    for (int i = 0; i < 8 && mq.size() != 0; i++) idle();
    idle();
    check_eq("drain_sb_empty", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
